// File: rtl/shift_issue_unit_pkg.sv
// rtl/shift_issue_unit_pkg.sv - shared op encoding, command layout and helpers for the shift issue unit
package shift_pkg;

    localparam int OP_W  = 3;
    localparam int DEF_N = 8;

    // Shift operations understood by the external barrel shifter.
    typedef enum logic [OP_W-1:0] {
        SRL = 3'd0,
        SRA = 3'd1,
        SLL = 3'd2,
        ROR = 3'd3,
        ROL = 3'd4
    } shift_op_e;

    // Command layout at the default data width; the unit builds the same
    // layout locally for its configured N.
    typedef struct packed {
        logic [DEF_N-1:0]         data;
        logic [$clog2(DEF_N)-1:0] shamt;
        logic [OP_W-1:0]          op;
    } shift_cmd_t;

    // Codes above ROL have no defined shift behaviour.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_W'(ROL);
    endfunction

endpackage

// File: rtl/shift_issue_unit_fifo.sv
// rtl/shift_issue_unit_fifo.sv - command FIFO with wrap-bit pointers
module shift_cmd_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers differ only in the wrap bit when full, match exactly when empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Advance each pointer on its own handshake; natural overflow gives the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers clear immediately on reset, discarding queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/shift_issue_unit.sv
// rtl/shift_issue_unit.sv - queues shift commands, drives an external barrel shifter, registers results (option: SHIFT_ISSUE_ILLEGAL_DROP_EN)
module shift_issue_unit
    import shift_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int DEPTH = 4,
    localparam int SHW   = $clog2(N),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic [SHW-1:0]  in_shamt,
    input  logic [OP_W-1:0] in_op,
    output logic [N-1:0]    sh_data_in,
    output logic [SHW-1:0]  sh_shift_num,
    output logic [OP_W-1:0] sh_op,
    input  logic [N-1:0]    sh_data_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [OP_W-1:0] out_op,
    output logic [LW-1:0]   fifo_level
`ifdef SHIFT_ISSUE_ILLEGAL_DROP_EN
    ,
    output logic [7:0]      illegal_cnt
`endif
);

    typedef struct packed {
        logic [N-1:0]    data;
        logic [SHW-1:0]  shamt;
        logic [OP_W-1:0] op;
    } cmd_t;

    cmd_t            wr_cmd;
    cmd_t            head_cmd;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q,  out_data_d;
    logic [OP_W-1:0] out_op_q,    out_op_d;

    // No bypass: a full queue refuses input even if it pops this cycle.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;

    assign wr_cmd.data  = in_data;
    assign wr_cmd.shamt = in_shamt;
    assign wr_cmd.op    = in_op;

`ifdef SHIFT_ISSUE_ILLEGAL_DROP_EN
    logic [7:0] illegal_cnt_q, illegal_cnt_d;
    logic       cmd_legal;

    assign cmd_legal   = op_is_legal(in_op);
    assign fifo_push   = accept && cmd_legal;
    assign illegal_cnt = illegal_cnt_q;

    // Count dropped commands, saturating so the counter never wraps back to a small value.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && !cmd_legal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    // Illegal-command counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_cnt_q <= '0;
        else        illegal_cnt_q <= illegal_cnt_d;
    end
`else
    assign fifo_push = accept;
`endif

    // The head moves into the output register whenever that register is free or draining.
    assign fifo_pop = !fifo_empty && (!out_valid_q || out_ready);

    shift_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wr_cmd),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Present the head to the shifter; hold the shifter inputs at zero while idle.
    always_comb begin
        sh_data_in   = '0;
        sh_shift_num = '0;
        sh_op        = '0;
        if (!fifo_empty) begin
            sh_data_in   = head_cmd.data;
            sh_shift_num = head_cmd.shamt;
            sh_op        = head_cmd.op;
        end
    end

    // Capture the shifter result on a pop; otherwise hold, dropping valid once consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_op_d    = out_op_q;
        if (fifo_pop) begin
            out_valid_d = 1'b1;
            out_data_d  = sh_data_out;
            out_op_d    = head_cmd.op;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any pending result at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_op_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_op_q    <= out_op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_op    = out_op_q;

endmodule
